// File: rtl/screen_pkg.sv
// Shared constants and state encoding for the column-height screen renderers.
package screen_pkg;

    localparam int COLS    = 160;
    localparam int ROWS    = 120;
    localparam int H_SHIFT = 2;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int ADDR_W  = 10;
    localparam int HGT_W   = 9;
    localparam int COL_W   = 3;

    localparam logic [COL_W-1:0] FG = 3'b010;
    localparam logic [COL_W-1:0] BG = 3'b000;

    localparam logic [X_W-1:0] LAST_COL = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] LAST_ROW = Y_W'(ROWS - 1);
    localparam logic [Y_W-1:0] ROWS_Y   = Y_W'(ROWS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        DRAW    = 3'd3,
        FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/col_height_scale.sv
// Maps a raw 9-bit RAM height onto a screen-row count, saturating at ROWS.
module col_height_scale
    import screen_pkg::*;
(
    input  logic [HGT_W-1:0] ram_q,
    output logic [Y_W-1:0]   h
);

    logic [HGT_W-1:0] shifted;

    always_comb begin
        shifted = ram_q >> H_SHIFT;
        h = (shifted > HGT_W'(ROWS)) ? ROWS_Y : shifted[Y_W-1:0];
    end

endmodule

// File: rtl/screen_plotter.sv
// Streams one full frame of column-height bars into the vga_adapter, one pixel per cycle,
// repainting every pixel so no separate clear pass is needed.
module screen_plotter
    import screen_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [HGT_W-1:0]  ram_q,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [X_W-1:0]    col, col_n;
    logic [Y_W-1:0]    row, row_n;
    logic [Y_W-1:0]    h, h_n, h_scaled;
    logic              fill_n;

    col_height_scale u_scale (
        .ram_q (ram_q),
        .h     (h_scaled)
    );

    always_comb begin
        state_n = state;
        base_n  = base;
        col_n   = col;
        row_n   = row;
        h_n     = h;
        case (state)
            IDLE: begin
                if (start) begin
                    base_n  = base_addr;
                    col_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = CAPTURE;
            CAPTURE: begin
                h_n     = h_scaled;
                row_n   = '0;
                state_n = DRAW;
            end
            DRAW: begin
                if (row == LAST_ROW) begin
                    if (col == LAST_COL) begin
                        state_n = FINISH;
                    end else begin
                        col_n   = col + 1'b1;
                        state_n = FETCH;
                    end
                end else begin
                    row_n = row + 1'b1;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A row is filled when it lies within the bottom h rows of the column.
        fill_n = ({1'b0, row_n} >= ({1'b0, ROWS_Y} - {1'b0, h_n}));
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            col      <= '0;
            row      <= '0;
            h        <= '0;
            ram_addr <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= BG;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            base  <= base_n;
            col   <= col_n;
            row   <= row_n;
            h     <= h_n;
            if (state_n == FETCH) begin
                ram_addr <= base_n + ADDR_W'(col_n);
            end
            plot <= (state_n == DRAW);
            if (state_n == DRAW) begin
                x      <= col_n;
                y      <= row_n;
                colour <= fill_n ? FG : BG;
            end
            done <= (state_n == FINISH);
            busy <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_screen_plotter.sv
// Frame-level bench: a synchronous RAM model feeds the plotter and every plot is compared
// against colours computed directly from the RAM contents.
module tb_screen_plotter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] base_addr;
    logic [9:0] ram_addr;
    logic [8:0] ram_q;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    logic [8:0] mem [1024];
    logic [2:0] dutPix [160][120];
    int         frameBase;
    int         checks = 0;
    int         errors = 0;

    localparam logic [2:0] FG_C = 3'b010;
    localparam logic [2:0] BG_C = 3'b000;

    screen_plotter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_q <= mem[ram_addr];

    // Expected colour from the frame's RAM image: bottom min(q/4,120) rows are filled.
    function automatic logic [2:0] expColour(input int c, input int r);
        int h;
        h = int'(mem[(frameBase + c) % 1024]) / 4;
        if (h > 120) h = 120;
        return (r >= 120 - h) ? FG_C : BG_C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int baseIn, input int repulseAt, input bit repulseDone, input int resetAt);
        int pix;
        int k;
        bit seenDone;
        for (int c = 0; c < 160; c++)
            for (int r = 0; r < 120; r++)
                dutPix[c][r] = 3'b111;
        frameBase = baseIn;
        base_addr = 10'(baseIn);
        start     = 1'b1;
        pix       = 0;
        k         = 0;
        seenDone  = 1'b0;
        while (!seenDone && k < 25000) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            if (k == repulseAt) begin
                start     = 1'b1;
                base_addr = 10'($urandom);
            end
            if (k == 1) checkOutput("busy_after_start", {31'd0, busy}, 1);
            if (resetAt > 0 && k == resetAt) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                checkOutput("abort_plot", {31'd0, plot}, 0);
                checkOutput("abort_busy", {31'd0, busy}, 0);
                checkOutput("abort_done", {31'd0, done}, 0);
                return;
            end
            if (plot) begin
                if (pix >= 19200) begin
                    checkOutput("plot_beyond_frame", {31'd0, plot}, 0);
                end else begin
                    checkOutput("pixel_x", {24'd0, x}, pix / 120);
                    checkOutput("pixel_y", {25'd0, y}, pix % 120);
                    checkOutput("pixel_colour", {29'd0, colour}, {29'd0, expColour(pix / 120, pix % 120)});
                    if (x < 160 && y < 120) dutPix[x][y] = colour;
                    pix++;
                end
            end
            if (done) begin
                seenDone = 1'b1;
                checkOutput("done_cycle", k, 19521);
                checkOutput("plot_count", pix, 19200);
                checkOutput("done_plot_low", {31'd0, plot}, 0);
            end
        end
        if (!seenDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=no_done expected=done_by_19521");
        end
        start = repulseDone;
        if (repulseDone) base_addr = 10'($urandom);
        @(negedge clock);
        start = 1'b0;
        checkOutput("busy_after_done", {31'd0, busy}, 0);
        checkOutput("done_single", {31'd0, done}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("idle_busy", {31'd0, busy}, 0);
            checkOutput("idle_plot", {31'd0, plot}, 0);
        end
    endtask

    initial begin
        int b;
        int picks [7];
        picks = '{0, 3, 4, 479, 480, 481, 511};
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_ram_addr", {22'd0, ram_addr}, 0);
        checkOutput("reset_x", {24'd0, x}, 0);
        checkOutput("reset_y", {25'd0, y}, 0);
        checkOutput("reset_colour", {29'd0, colour}, 0);
        checkOutput("reset_plot", {31'd0, plot}, 0);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_done", {31'd0, done}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Mostly-empty frame with one bar, plus ignored start pulses mid-frame and on done.
        mem[5] = 9'd200;
        applyStimulus(0, 500, 1'b1, 0);
        checkOutput("pin_5_69_bg", {29'd0, dutPix[5][69]}, {29'd0, BG_C});
        checkOutput("pin_5_70_fg", {29'd0, dutPix[5][70]}, {29'd0, FG_C});
        checkOutput("pin_4_119_bg", {29'd0, dutPix[4][119]}, {29'd0, BG_C});
        checkOutput("pin_0_0_bg", {29'd0, dutPix[0][0]}, {29'd0, BG_C});
        checkOutput("pin_159_119_bg", {29'd0, dutPix[159][119]}, {29'd0, BG_C});

        // Wrapping base with boundary heights around the clamp and zero.
        for (int c = 0; c < 160; c++)
            mem[(1000 + c) % 1024] = 9'(picks[$urandom_range(0, 6)]);
        mem[1023] = 9'd40;
        mem[0]    = 9'd480;
        mem[1]    = 9'd511;
        mem[2]    = 9'd481;
        mem[3]    = 9'd479;
        mem[4]    = 9'd4;
        mem[5]    = 9'd3;
        applyStimulus(1000, 0, 1'b0, 0);
        checkOutput("pin_23_110_fg", {29'd0, dutPix[23][110]}, {29'd0, FG_C});
        checkOutput("pin_23_109_bg", {29'd0, dutPix[23][109]}, {29'd0, BG_C});
        checkOutput("pin_24_0_fg", {29'd0, dutPix[24][0]}, {29'd0, FG_C});
        checkOutput("pin_25_0_fg", {29'd0, dutPix[25][0]}, {29'd0, FG_C});
        checkOutput("pin_26_0_fg", {29'd0, dutPix[26][0]}, {29'd0, FG_C});
        checkOutput("pin_27_0_bg", {29'd0, dutPix[27][0]}, {29'd0, BG_C});
        checkOutput("pin_27_1_fg", {29'd0, dutPix[27][1]}, {29'd0, FG_C});
        checkOutput("pin_28_119_fg", {29'd0, dutPix[28][119]}, {29'd0, FG_C});
        checkOutput("pin_28_118_bg", {29'd0, dutPix[28][118]}, {29'd0, BG_C});
        checkOutput("pin_29_119_bg", {29'd0, dutPix[29][119]}, {29'd0, BG_C});

        // Random frame aborted by reset, then a clean random frame.
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 511));
        b = $urandom_range(0, 1023);
        applyStimulus(b, 0, 1'b0, 3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("post_abort_done", {31'd0, done}, 0);
            checkOutput("post_abort_busy", {31'd0, busy}, 0);
            checkOutput("post_abort_plot", {31'd0, plot}, 0);
        end
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 511));
        b = $urandom_range(0, 1023);
        applyStimulus(b, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
